// File: rtl/lif_param_serializer.sv
// Host-side serializer for the LIF neuron configuration link: latches one 24-bit
// parameter frame, shifts it out MSB-first, then waits for params_ready or times out.
module lif_param_serializer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [2:0] weight_a,
  input  logic [2:0] weight_b,
  input  logic [1:0] leak_config,
  input  logic [7:0] threshold_min,
  input  logic [7:0] threshold_max,
  input  logic       params_ready,
  output logic       load_mode,
  output logic       serial_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Frame width is fixed by the field widths 3+3+2+8+8.
  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACK
  } state_t;

  state_t                r_state,  w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift,  w_shift_nxt;
  logic [BW-1:0]         r_bitcnt, w_bitcnt_nxt;
  logic [TW-1:0]         r_tocnt,  w_tocnt_nxt;
  logic                  r_load,   w_load_nxt;
  logic                  r_sdata,  w_sdata_nxt;
  logic                  r_busy,   w_busy_nxt;
  logic                  r_done,   w_done_nxt;
  logic                  r_error,  w_error_nxt;

  logic [FRAME_BITS-1:0] w_frame;
  logic [FRAME_BITS-1:0] w_shifted;

  assign w_frame   = {weight_a, weight_b, leak_config, threshold_min, threshold_max};
  assign w_shifted = {r_shift[FRAME_BITS-2:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_tocnt  <= '0;
      r_load   <= 1'b0;
      r_sdata  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_tocnt  <= w_tocnt_nxt;
      r_load   <= w_load_nxt;
      r_sdata  <= w_sdata_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
    end
  end

  // With enable low every next value equals the current one, freezing the block.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_tocnt_nxt  = r_tocnt;
    w_load_nxt   = r_load;
    w_sdata_nxt  = r_sdata;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_error_nxt  = r_error;

    if (enable) begin
      unique case (r_state)
        S_IDLE: begin
          w_done_nxt = 1'b0;
          if (start) begin
            w_state_nxt  = S_LOAD;
            w_shift_nxt  = w_frame;
            w_bitcnt_nxt = '0;
            w_load_nxt   = 1'b1;
            w_sdata_nxt  = w_frame[FRAME_BITS-1];
            w_busy_nxt   = 1'b1;
            w_error_nxt  = 1'b0;
          end
        end

        S_LOAD: begin
          if (r_bitcnt == LAST_BIT) begin
            w_state_nxt = S_WAIT_ACK;
            w_load_nxt  = 1'b0;
            w_sdata_nxt = 1'b0;
            w_tocnt_nxt = '0;
          end else begin
            w_shift_nxt  = w_shifted;
            w_sdata_nxt  = w_shifted[FRAME_BITS-1];
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end

        S_WAIT_ACK: begin
          // An acknowledge on the final timeout cycle still counts as success.
          if (params_ready) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else if (r_tocnt == TO_LAST) begin
            w_state_nxt = S_IDLE;
            w_error_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_tocnt_nxt = r_tocnt + 1'b1;
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign load_mode   = r_load;
  assign serial_data = r_sdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_lif_param_serializer.sv
// Bench for lif_param_serializer: a transaction-level model (phase count since start)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_lif_param_serializer;
  localparam int ACK_TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       params_ready = 1'b0;
  logic [2:0] weight_a = '0;
  logic [2:0] weight_b = '0;
  logic [1:0] leak_config = '0;
  logic [7:0] threshold_min = '0;
  logic [7:0] threshold_max = '0;
  logic       load_mode, serial_data, busy, done, error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lif_param_serializer #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .weight_a(weight_a), .weight_b(weight_b), .leak_config(leak_config),
    .threshold_min(threshold_min), .threshold_max(threshold_max),
    .params_ready(params_ready), .load_mode(load_mode), .serial_data(serial_data),
    .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_p counts enabled edges since the accepted start. Bits occupy phases
  // 0..23, the ack window is phases 25..24+ACK_TO.
  bit          m_active = 1'b0;
  int          m_p = 0;
  logic [23:0] m_frame = '0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_p <= 0; m_frame <= '0; m_done <= 1'b0; m_err <= 1'b0;
    end else if (enable) begin
      if (m_active) begin
        if (m_p + 1 >= 25 && params_ready) begin
          m_done <= 1'b1; m_active <= 1'b0;
        end else if (m_p + 1 == 24 + ACK_TO) begin
          m_err <= 1'b1; m_active <= 1'b0;
        end else begin
          m_p <= m_p + 1;
        end
      end else begin
        m_done <= 1'b0;
        if (start) begin
          m_active <= 1'b1; m_p <= 0; m_err <= 1'b0;
          m_frame <= {weight_a, weight_b, leak_config, threshold_min, threshold_max};
        end
      end
    end
  end

  always @(negedge clk) begin
    logic e_load, e_ser;
    e_load = m_active && (m_p <= 23);
    e_ser  = e_load ? m_frame[23 - m_p] : 1'b0;
    check("load_mode", 32'(load_mode), 32'(e_load));
    check("serial_data", 32'(serial_data), 32'(e_ser));
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("error", 32'(error), 32'(m_err));
  end

  // Sends one frame and observes it from the driver side (samples at negedge+1).
  task automatic send(input logic [23:0] fr, input int ack_after, input int gap_at,
                      input bit poke, output logic [23:0] got, output int hi,
                      output int dn, output int to_at, output logic e_first);
    bit   fallen, prev_en, last;
    int   since, tail;
    @(negedge clk); #1;
    {weight_a, weight_b, leak_config, threshold_min, threshold_max} = fr;
    enable = 1'b1; start = 1'b1; params_ready = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    {weight_a, weight_b, leak_config, threshold_min, threshold_max} = ~fr;
    got = '0; hi = 0; dn = 0; to_at = -1; fallen = 1'b0; since = 0; tail = 0;
    prev_en = 1'b1; last = 1'b0; e_first = error;
    for (int c = 0; c < 120 && tail < 3; c++) begin
      if (load_mode) begin
        if (prev_en) begin got = {got[22:0], serial_data}; last = serial_data; end
        else check("gap_hold", 32'(serial_data), 32'(last));
        hi++;
      end else if (hi > 0) begin
        if (fallen) since++; else fallen = 1'b1;
      end
      if (done) dn++;
      if (error && to_at < 0 && fallen) to_at = since;
      if (fallen && !busy) tail++;
      enable       = !(gap_at > 0 && hi >= gap_at && hi < gap_at + 3);
      prev_en      = enable;
      params_ready = fallen && (since == ack_after);
      start        = poke && (hi == 5);
      @(negedge clk); #1;
    end
    check("frame_end_reached", 32'(tail), 32'd3);
    params_ready = 1'b0; start = 1'b0; enable = 1'b1;
  endtask

  initial begin
    logic [23:0] got;
    int hi, dn, to_at, rises, lowrun, first_gap;
    logic e_first;

    #1 reset = 1'b1;
    #10;
    check("reset_state", 32'({load_mode, serial_data, busy, done, error}), 32'd0);
    @(negedge clk); #1 reset = 1'b0; enable = 1'b1;

    // Reference frame, ack two cycles after load_mode falls.
    send(24'hAB3CA5, 2, 0, 1'b0, got, hi, dn, to_at, e_first);
    check("frame_bits", 32'(got), 32'hAB3CA5);
    check("frame_len", 32'(hi), 32'd24);
    check("done_pulses", 32'(dn), 32'd1);
    check("ack_no_error", 32'(to_at), 32'hFFFF_FFFF);

    // Timeout: no acknowledge at all.
    send(24'h5A_0F81, -1, 0, 1'b0, got, hi, dn, to_at, e_first);
    check("timeout_cycles", 32'(to_at), 32'd16);
    check("timeout_no_done", 32'(dn), 32'd0);
    check("timeout_error_sticky", 32'(error), 32'd1);

    // Next start clears error; start pulsed mid-frame is ignored.
    send(24'h13_57E2, 3, 0, 1'b1, got, hi, dn, to_at, e_first);
    check("start_clears_error", 32'(e_first), 32'd0);
    check("poke_frame_bits", 32'(got), 32'h1357E2);
    check("poke_not_queued", 32'(busy), 32'd0);

    // Enable gap of 3 cycles at bit 10.
    send(24'hC3_96F0, 1, 10, 1'b0, got, hi, dn, to_at, e_first);
    check("gap_frame_bits", 32'(got), 32'hC396F0);
    check("gap_frame_len", 32'(hi), 32'd27);

    // Acknowledge on the exact timeout cycle.
    send(24'hFF_0001, 15, 0, 1'b0, got, hi, dn, to_at, e_first);
    check("race_done", 32'(dn), 32'd1);
    check("race_no_error", 32'(error), 32'd0);

    // Reset mid-LOAD drops outputs asynchronously; next frame is complete.
    @(negedge clk); #1;
    {weight_a, weight_b, leak_config, threshold_min, threshold_max} = 24'hFFFFFF;
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("reset_async", 32'({load_mode, serial_data, busy, done, error}), 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    send(24'h80_0001, 0, 0, 1'b0, got, hi, dn, to_at, e_first);
    check("post_reset_bits", 32'(got), 32'h800001);
    check("post_reset_len", 32'(hi), 32'd24);

    // start held high with immediate ack: back-to-back frames, 2 low cycles between.
    @(negedge clk); #1;
    {weight_a, weight_b, leak_config, threshold_min, threshold_max} = 24'h2468AC;
    start = 1'b1; params_ready = 1'b1;
    rises = 0; lowrun = 0; first_gap = -1;
    for (int c = 0; c < 100 && rises < 2; c++) begin
      @(negedge clk); #1;
      if (load_mode) begin
        if (lowrun > 0 || rises == 0) begin
          if (rises == 1) first_gap = lowrun;
          rises++;
        end
        lowrun = 0;
      end else begin
        lowrun++;
      end
    end
    start = 1'b0;
    check("held_two_frames", 32'(rises), 32'd2);
    check("held_gap", 32'(first_gap), 32'd2);
    for (int c = 0; c < 60 && busy; c++) @(negedge clk);
    #1 params_ready = 1'b0;
    check("held_second_done", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      reset         = ($urandom_range(0, 799) == 0);
      enable        = ($urandom_range(0, 9) != 0);
      start         = ($urandom_range(0, 5) == 0);
      params_ready  = ($urandom_range(0, 19) == 0);
      weight_a      = 3'($urandom);
      weight_b      = 3'($urandom);
      leak_config   = 2'($urandom);
      threshold_min = 8'($urandom);
      threshold_max = 8'($urandom);
    end
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
